// File: rtl/load_store_unit_pkg.sv
// Shared funct3 encodings and FSM state type for the load/store unit.
package load_store_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {LSU_IDLE, LSU_REQ, LSU_WAIT, LSU_DONE} lsu_state_t;

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering for stores, extraction/extension for loads, and the
// alignment/size legality check on an incoming request.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  chk_size,
    input  logic [1:0]  chk_addr,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    output logic        illegal,
    input  logic [2:0]  ld_size,
    input  logic [1:0]  ld_addr,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        illegal = 1'b0;
        case (chk_size)
            F3_LB, F3_LBU: illegal = 1'b0;
            F3_LH, F3_LHU: illegal = chk_addr[0];
            F3_LW:         illegal = |chk_addr;
            default:       illegal = 1'b1;
        endcase
    end

    // Store funct3 shares the low two bits with the load encodings.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        case (chk_size[1:0])
            F3_SB[1:0]: begin
                st_be    = 4'b0001 << chk_addr;
                st_wdata = {4{st_data[7:0]}};
            end
            F3_SH[1:0]: begin
                st_be    = chk_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = st_data;
            end
        endcase
    end

    always_comb begin
        byte_sel = rdata[{ld_addr, 3'b000} +: 8];
        half_sel = rdata[{ld_addr[1], 4'b0000} +: 16];
        case (ld_size)
            F3_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  ld_data = {24'd0, byte_sel};
            F3_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  ld_data = {16'd0, half_sel};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: issues one word-aligned bus access per memory instruction,
// stalls the core until it completes, and reports illegal or timed-out accesses.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrl_mem_write,
    input  logic        ctrl_mem2reg,
    input  logic [2:0]  ctrl_word_size,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        lsu_stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        access_fault,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_we,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_be,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_t  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] load_data_q, load_data_d;
    logic        load_valid_q, load_valid_d;
    logic        fault_q, fault_d;

    logic        access, illegal, timeout;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_ext;

    lsu_align u_align (
        .chk_size (ctrl_word_size),
        .chk_addr (addr[1:0]),
        .st_data  (store_data),
        .st_be    (st_be),
        .st_wdata (st_wdata),
        .illegal  (illegal),
        .ld_size  (size_q),
        .ld_addr  (addr_q[1:0]),
        .rdata    (mem_rsp_rdata),
        .ld_data  (ld_ext)
    );

    assign access  = ctrl_mem_write | ctrl_mem2reg;
    // Counter starts at 0 in the first REQ cycle, so TIMEOUT_CYCLES-1 marks the last allowed cycle.
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        we_d          = we_q;
        size_d        = size_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        cnt_d         = cnt_q;
        load_data_d   = load_data_q;
        load_valid_d  = 1'b0;
        fault_d       = 1'b0;
        lsu_stall     = 1'b0;
        mem_req_valid = 1'b0;
        access_fault  = fault_q;
        case (state_q)
            LSU_IDLE: begin
                if (access) begin
                    if (illegal) begin
                        access_fault = 1'b1;
                    end else begin
                        addr_d    = addr;
                        we_d      = ctrl_mem_write;
                        size_d    = ctrl_word_size;
                        wdata_d   = ctrl_mem_write ? st_wdata : 32'd0;
                        be_d      = ctrl_mem_write ? st_be : 4'b1111;
                        cnt_d     = '0;
                        state_d   = LSU_REQ;
                        lsu_stall = 1'b1;
                    end
                end
            end
            LSU_REQ: begin
                mem_req_valid = 1'b1;
                lsu_stall     = 1'b1;
                cnt_d         = cnt_q + CNT_W'(1);
                if (mem_req_ready) begin
                    state_d = we_q ? LSU_DONE : LSU_WAIT;
                end else if (timeout) begin
                    state_d     = LSU_DONE;
                    fault_d     = 1'b1;
                    load_data_d = 32'd0;
                end
            end
            LSU_WAIT: begin
                lsu_stall = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (mem_rsp_valid) begin
                    load_data_d  = ld_ext;
                    load_valid_d = 1'b1;
                    state_d      = LSU_DONE;
                end else if (timeout) begin
                    state_d     = LSU_DONE;
                    fault_d     = 1'b1;
                    load_data_d = 32'd0;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
        if (rst) begin
            lsu_stall     = 1'b0;
            mem_req_valid = 1'b0;
            access_fault  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LSU_IDLE;
            addr_q       <= 32'd0;
            we_q         <= 1'b0;
            size_q       <= 3'd0;
            wdata_q      <= 32'd0;
            be_q         <= 4'd0;
            cnt_q        <= '0;
            load_data_q  <= 32'd0;
            load_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            size_q       <= size_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            cnt_q        <= cnt_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            fault_q      <= fault_d;
        end
    end

    assign load_data     = load_data_q;
    assign load_valid    = load_valid_q;
    assign mem_req_we    = we_q;
    assign mem_req_addr  = {addr_q[31:2], 2'b00};
    assign mem_req_wdata = wdata_q;
    assign mem_req_be    = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a short timeout.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctrl_mem_write, ctrl_mem2reg;
    logic [2:0]  ctrl_word_size;
    logic [31:0] addr, store_data;
    logic        lsu_stall, load_valid, access_fault;
    logic [31:0] load_data;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_be;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;

    load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .ctrl_mem_write(ctrl_mem_write), .ctrl_mem2reg(ctrl_mem2reg),
        .ctrl_word_size(ctrl_word_size), .addr(addr), .store_data(store_data),
        .lsu_stall(lsu_stall), .load_data(load_data), .load_valid(load_valid),
        .access_fault(access_fault), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_req_be(mem_req_be), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_rdata(mem_rsp_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          stalls, lv_cnt, flt_cnt, req_cnt;
    logic [31:0] lv_data, flt_data, r_addr, r_wdata;
    logic [3:0]  r_be;
    logic        r_we;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one access for a single cycle, then observe ncyc cycles; the
    // response (if enabled) arrives the cycle after the request handshake.
    task automatic run(input logic w, input logic l, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rd, input logic rsp_en, input int ncyc);
        logic hs;
        hs = 1'b0;
        stalls = 0; lv_cnt = 0; flt_cnt = 0; req_cnt = 0;
        lv_data = 32'hx; flt_data = 32'hx; r_addr = 32'hx; r_wdata = 32'hx; r_be = 4'hx; r_we = 1'bx;
        ctrl_mem_write = w; ctrl_mem2reg = l; ctrl_word_size = sz;
        addr = a; store_data = d; mem_rsp_rdata = rd; mem_rsp_valid = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            #1;
            if (lsu_stall) stalls++;
            if (load_valid) begin lv_cnt++; lv_data = load_data; end
            if (access_fault) begin flt_cnt++; flt_data = load_data; end
            if (mem_req_valid) begin
                req_cnt++;
                r_addr = mem_req_addr; r_wdata = mem_req_wdata; r_be = mem_req_be; r_we = mem_req_we;
            end
            hs = mem_req_valid && mem_req_ready;
            @(posedge clk); #1;
            ctrl_mem_write = 1'b0; ctrl_mem2reg = 1'b0;
            mem_rsp_valid = hs && rsp_en && !w;
        end
        mem_rsp_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ctrl_mem_write = 1'b0; ctrl_mem2reg = 1'b1; ctrl_word_size = 3'b010;
        addr = 32'h0; store_data = 32'h0;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(lsu_stall), 32'd0);
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_load_valid", 32'(load_valid), 32'd0);
        chk("rst_fault", 32'(access_fault), 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        ctrl_mem2reg = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        run(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 32'h0, 1'b1, 6);
        chk("sb_addr", r_addr, 32'h0000_1000);
        chk("sb_be", 32'(r_be), 32'h8);
        chk("sb_wdata", r_wdata, 32'hDDDD_DDDD);
        chk("sb_we", 32'(r_we), 32'd1);
        chk("sb_stalls", 32'(stalls), 32'd2);
        chk("sb_no_lv", 32'(lv_cnt), 32'd0);

        run(1'b0, 1'b1, 3'b000, 32'h0000_2001, 32'h0, 32'h1234_80FF, 1'b1, 6);
        chk("lb_data", lv_data, 32'hFFFF_FF80);
        chk("lb_lv_pulse", 32'(lv_cnt), 32'd1);
        chk("lb_stalls", 32'(stalls), 32'd3);
        chk("lb_addr", r_addr, 32'h0000_2000);
        chk("lb_be", 32'(r_be), 32'hF);
        chk("lb_we", 32'(r_we), 32'd0);

        run(1'b0, 1'b1, 3'b100, 32'h0000_2001, 32'h0, 32'h1234_80FF, 1'b1, 6);
        chk("lbu_data", lv_data, 32'h0000_0080);
        chk("lbu_stalls", 32'(stalls), 32'd3);

        run(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_0000, 1'b1, 6);
        chk("lh_data", lv_data, 32'hFFFF_8001);
        run(1'b0, 1'b1, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_0000, 1'b1, 6);
        chk("lhu_data", lv_data, 32'h0000_8001);

        run(1'b0, 1'b1, 3'b010, 32'h0000_2004, 32'h0, 32'hCAFE_F00D, 1'b1, 6);
        chk("lw_data", lv_data, 32'hCAFE_F00D);

        run(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h1122_3344, 32'h0, 1'b1, 6);
        chk("sh_be", 32'(r_be), 32'hC);
        chk("sh_wdata", r_wdata, 32'h3344_3344);

        run(1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'hDEAD_BEEF, 32'h0, 1'b1, 6);
        chk("sw_be", 32'(r_be), 32'hF);
        chk("sw_wdata", r_wdata, 32'hDEAD_BEEF);

        run(1'b1, 1'b1, 3'b010, 32'h0000_3008, 32'h0102_0304, 32'h0, 1'b1, 6);
        chk("both_we", 32'(r_we), 32'd1);
        chk("both_stalls", 32'(stalls), 32'd2);
        chk("both_no_lv", 32'(lv_cnt), 32'd0);

        run(1'b0, 1'b1, 3'b010, 32'h0000_2002, 32'h0, 32'h0, 1'b1, 6);
        chk("lw_mis_fault", 32'(flt_cnt), 32'd1);
        chk("lw_mis_req", 32'(req_cnt), 32'd0);
        chk("lw_mis_stall", 32'(stalls), 32'd0);
        run(1'b0, 1'b1, 3'b011, 32'h0000_2000, 32'h0, 32'h0, 1'b1, 6);
        chk("f3_011_fault", 32'(flt_cnt), 32'd1);
        chk("f3_011_req", 32'(req_cnt), 32'd0);
        chk("f3_011_stall", 32'(stalls), 32'd0);
        run(1'b1, 1'b0, 3'b001, 32'h0000_2001, 32'h0, 32'h0, 1'b1, 6);
        chk("sh_odd_fault", 32'(flt_cnt), 32'd1);
        chk("sh_odd_req", 32'(req_cnt), 32'd0);

        // Back-pressure: request must stay stable while ready is low.
        mem_req_ready = 1'b0;
        ctrl_mem_write = 1'b1; ctrl_word_size = 3'b001; addr = 32'h0000_4002; store_data = 32'hCAFE_1234;
        #1;
        @(posedge clk); #1;
        ctrl_mem_write = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_valid", 32'(mem_req_valid), 32'd1);
            chk("bp_addr", mem_req_addr, 32'h0000_4000);
            chk("bp_wdata", mem_req_wdata, 32'h1234_1234);
            chk("bp_be", 32'(mem_req_be), 32'hC);
            chk("bp_stall", 32'(lsu_stall), 32'd1);
            @(posedge clk); #1;
        end
        mem_req_ready = 1'b1;
        #1;
        chk("bp_hs_valid", 32'(mem_req_valid), 32'd1);
        @(posedge clk); #1;
        chk("bp_done_stall", 32'(lsu_stall), 32'd0);
        chk("bp_done_valid", 32'(mem_req_valid), 32'd0);
        @(posedge clk); #1;

        mem_req_ready = 1'b0;
        run(1'b0, 1'b1, 3'b010, 32'h0000_5000, 32'h0, 32'h0, 1'b1, 24);
        chk("to_req_cycles", 32'(req_cnt), 32'd16);
        chk("to_req_fault", 32'(flt_cnt), 32'd1);
        chk("to_req_stalls", 32'(stalls), 32'd17);
        chk("to_req_no_lv", 32'(lv_cnt), 32'd0);
        chk("to_req_data", flt_data, 32'd0);
        mem_req_ready = 1'b1;

        run(1'b0, 1'b1, 3'b000, 32'h0000_2001, 32'h0, 32'h1234_80FF, 1'b1, 6);
        run(1'b0, 1'b1, 3'b010, 32'h0000_5004, 32'h0, 32'h0, 1'b0, 24);
        chk("to_wait_req", 32'(req_cnt), 32'd1);
        chk("to_wait_fault", 32'(flt_cnt), 32'd1);
        chk("to_wait_stalls", 32'(stalls), 32'd17);
        chk("to_wait_no_lv", 32'(lv_cnt), 32'd0);
        chk("to_wait_data", flt_data, 32'd0);
        #1;
        chk("to_idle_stall", 32'(lsu_stall), 32'd0);

        // Reset while waiting for the read response.
        ctrl_mem2reg = 1'b1; ctrl_word_size = 3'b010; addr = 32'h0000_6000; mem_rsp_rdata = 32'h55AA_55AA;
        #1;
        @(posedge clk); #1;
        ctrl_mem2reg = 1'b0;
        #1;
        chk("rw_req_valid", 32'(mem_req_valid), 32'd1);
        @(posedge clk); #1;
        chk("rw_wait_stall", 32'(lsu_stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("rw_rst_stall", 32'(lsu_stall), 32'd0);
        chk("rw_rst_valid", 32'(mem_req_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_rsp_valid = 1'b1;
        lv_cnt = 0; stalls = 0; req_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (load_valid) lv_cnt++;
            if (lsu_stall) stalls++;
            if (mem_req_valid) req_cnt++;
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0;
        end
        chk("rw_no_lv", 32'(lv_cnt), 32'd0);
        chk("rw_no_stall", 32'(stalls), 32'd0);
        chk("rw_no_req", 32'(req_cnt), 32'd0);
        chk("rw_load_data", load_data, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
